// File: rtl/dsi_pack_pkg.sv
// dsi_word_packer shared types, markers and host-visible word layout.
// Trailer support is selected with the PACKER_TRAILER_EN macro.
package dsi_pack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    DATA,
    FLUSH,
    TRAIL,
    DROP
  } state_t;

  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam logic [7:0] TRL_MARK = 8'h5A;

  // Field offsets, shared with the host-side parser
  localparam int HDR_MARK_LSB  = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int TRL_MARK_LSB  = 24;
  localparam int TRL_TRUNC_BIT = 17;
  localparam int TRL_LEN_LSB   = 0;

  function automatic logic [31:0] hdr_word(
    input logic [7:0] seq
  );
    logic [31:0] w;
    w = 32'(HDR_MARK) << HDR_MARK_LSB;
    w[HDR_SEQ_LSB +: 8] = seq;
    return w;
  endfunction

  function automatic logic [31:0] trl_word(
    input logic        trunc,
    input logic [15:0] len
  );
    logic [31:0] w;
    w = 32'(TRL_MARK) << TRL_MARK_LSB;
    w[TRL_TRUNC_BIT] = trunc;
    w[TRL_LEN_LSB +: 16] = len;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dsi_word_packer.sv
// Packs DSI bytes into header/data/trailer words for the HSPI FIFO.
// Define PACKER_TRAILER_EN to emit trailer words (trunc flag, length).
module dsi_word_packer
  import dsi_pack_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  output logic        rx_ready,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  input  logic        fifo_almost_full,
  output logic [15:0] drop_cnt,
  output logic [7:0]  pkt_seq
);

  state_t      state;
  logic        rdy_en;
  logic [31:0] word;
  logic [1:0]  idx;
  logic        eop_pend;
  logic [3:0]  lane_be;
  logic        acc;
`ifdef PACKER_TRAILER_EN
  logic [15:0] len;
  logic        trunc;
`endif

  assign lane_be = 4'b0001 << idx;
  assign rx_ready = rdy_en &&
    (state == IDLE || state == DATA || state == DROP);
  assign acc = rx_valid && rx_ready;

  // Packet FSM, lane packing, FIFO write and counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      rdy_en       <= 1'b0;
      word         <= '0;
      idx          <= '0;
      eop_pend     <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      drop_cnt     <= '0;
      pkt_seq      <= '0;
`ifdef PACKER_TRAILER_EN
      len          <= '0;
      trunc        <= 1'b0;
`endif
    end else begin
      rdy_en     <= 1'b1;
      fifo_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc && rx_sop) begin
            word     <= {24'h0, rx_byte};
            idx      <= 2'd1;
            eop_pend <= rx_eop;
`ifdef PACKER_TRAILER_EN
            len      <= 16'd1;
            trunc    <= 1'b0;
`endif
            state    <= HEAD;
          end
        end
        HEAD: begin
          if (fifo_almost_full) begin
            drop_cnt <= sat_inc16(drop_cnt);
            if (eop_pend) begin
              pkt_seq <= pkt_seq + 8'd1;
              state   <= IDLE;
            end else begin
              state <= DROP;
            end
          end else begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= hdr_word(pkt_seq);
            state        <= eop_pend ? FLUSH : DATA;
          end
        end
        DATA: begin
          if (acc) begin
            if (rx_sop) begin
`ifdef PACKER_TRAILER_EN
              trunc <= 1'b1;
              state <= (idx != 2'd0) ? FLUSH : TRAIL;
`else
              if (idx != 2'd0) begin
                state <= FLUSH;
              end else begin
                pkt_seq <= pkt_seq + 8'd1;
                state   <= IDLE;
              end
`endif
            end else begin
              idx <= idx + 2'd1;
`ifdef PACKER_TRAILER_EN
              len <= sat_inc16(len);
`endif
              if (idx == 2'd3) begin
                word <= '0;
                if (fifo_almost_full) begin
                  drop_cnt <= sat_inc16(drop_cnt);
                  if (rx_eop) begin
                    pkt_seq <= pkt_seq + 8'd1;
                    state   <= IDLE;
                  end else begin
                    state <= DROP;
                  end
                end else begin
                  fifo_wr_en   <= 1'b1;
                  fifo_wr_data <= {rx_byte, word[23:0]};
                  if (rx_eop) begin
`ifdef PACKER_TRAILER_EN
                    state <= TRAIL;
`else
                    pkt_seq <= pkt_seq + 8'd1;
                    state   <= IDLE;
`endif
                  end
                end
              end else begin
                for (int i = 0; i < 4; i++) begin
                  if (lane_be[i]) word[8*i +: 8] <= rx_byte;
                end
                if (rx_eop) state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          word <= '0;
          if (fifo_almost_full) begin
            drop_cnt <= sat_inc16(drop_cnt);
            pkt_seq  <= pkt_seq + 8'd1;
            state    <= IDLE;
          end else begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= word;
`ifdef PACKER_TRAILER_EN
            state <= TRAIL;
`else
            pkt_seq <= pkt_seq + 8'd1;
            state   <= IDLE;
`endif
          end
        end
`ifdef PACKER_TRAILER_EN
        TRAIL: begin
          if (fifo_almost_full) begin
            drop_cnt <= sat_inc16(drop_cnt);
          end else begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= trl_word(trunc, len);
          end
          pkt_seq <= pkt_seq + 8'd1;
          state   <= IDLE;
        end
`endif
        DROP: begin
          if (acc && rx_eop) begin
            pkt_seq <= pkt_seq + 8'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_word_packer.sv
// Directed self-checking bench for dsi_word_packer.
// Expectations follow PACKER_TRAILER_EN when it is defined.
module tb_dsi_word_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_ready;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_almost_full;
  logic [15:0] drop_cnt;
  logic [7:0]  pkt_seq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] wq[$];

  dsi_word_packer dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .rx_sop           (rx_sop),
    .rx_eop           (rx_eop),
    .rx_ready         (rx_ready),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_almost_full (fifo_almost_full),
    .drop_cnt         (drop_cnt),
    .pkt_seq          (pkt_seq)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (fifo_wr_en) wq.push_back(fifo_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic s,
                      input logic e);
    int n;
    n = 0;
    rx_byte  = b;
    rx_sop   = s;
    rx_eop   = e;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 50) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout: byte %h never accepted", b);
    end
    @(negedge sys_clk);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic expect_word(input string tag,
                             input logic [31:0] exp);
    int n;
    logic [31:0] got;
    n = 0;
    while (wq.size() == 0 && n < 20) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    n_assert++;
    assert (wq.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: got no write expected %h", tag, exp);
    end
    if (wq.size() != 0) begin
      got = wq.pop_front();
      chk(tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    repeat (6) @(negedge sys_clk);
    #1;
    chk(tag, 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  initial begin
    sys_rst          = 1'b1;
    rx_byte          = 8'h00;
    rx_valid         = 1'b0;
    rx_sop           = 1'b0;
    rx_eop           = 1'b0;
    fifo_almost_full = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_seq", 32'(pkt_seq), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("ready_after_rst", 32'(rx_ready), 32'd1);

    // stray non-sop byte is discarded in IDLE
    send(8'hEE, 1'b0, 1'b0);
    drain("stray_no_write");

    // 8-byte aligned packet, header latency checked
    send(8'h01, 1'b1, 1'b0);
    chk("t1_hdr_not_yet", 32'(fifo_wr_en), 32'd0);
    @(negedge sys_clk);
    chk("t1_hdr_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t1_hdr_data", fifo_wr_data, 32'hA500_0000);
    for (int i = 2; i <= 8; i++)
      send(8'(i), 1'b0, i == 8);
    expect_word("t1_hdr", 32'hA500_0000);
    expect_word("t1_w0", 32'h0403_0201);
    expect_word("t1_w1", 32'h0807_0605);
`ifdef PACKER_TRAILER_EN
    expect_word("t1_trl", 32'h5A00_0008);
`endif
    drain("t1_extra");
    chk("t1_seq", 32'(pkt_seq), 32'd1);

    // 5-byte packet, partial last word
    for (int i = 0; i < 5; i++)
      send(8'h11 + 8'(i), i == 0, i == 4);
    expect_word("t2_hdr", 32'hA501_0000);
    expect_word("t2_w0", 32'h1413_1211);
    expect_word("t2_w1", 32'h0000_0015);
`ifdef PACKER_TRAILER_EN
    expect_word("t2_trl", 32'h5A00_0005);
`endif
    drain("t2_extra");

    // single byte with sop=eop
    send(8'hAA, 1'b1, 1'b1);
    expect_word("t3_hdr", 32'hA502_0000);
    expect_word("t3_w0", 32'h0000_00AA);
`ifdef PACKER_TRAILER_EN
    expect_word("t3_trl", 32'h5A00_0001);
`endif
    drain("t3_extra");

    // sop mid-packet truncates after 3 bytes
    send(8'h21, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b0);
    send(8'h31, 1'b1, 1'b0);
    expect_word("t4_hdr", 32'hA503_0000);
    expect_word("t4_w0", 32'h0023_2221);
`ifdef PACKER_TRAILER_EN
    expect_word("t4_trl", 32'h5A02_0003);
`endif
    drain("t4_extra");
    send(8'h41, 1'b1, 1'b1);
    expect_word("t4b_hdr", 32'hA504_0000);
    expect_word("t4b_w0", 32'h0000_0041);
`ifdef PACKER_TRAILER_EN
    expect_word("t4b_trl", 32'h5A00_0001);
`endif
    drain("t4b_extra");

    // almost_full during HEAD drops a 12-byte packet
    fifo_almost_full = 1'b1;
    for (int i = 0; i < 12; i++)
      send(8'h50 + 8'(i), i == 0, i == 11);
    fifo_almost_full = 1'b0;
    drain("t5_no_write");
    chk("t5_drop", 32'(drop_cnt), 32'd1);
    chk("t5_seq", 32'(pkt_seq), 32'd6);
    send(8'h61, 1'b1, 1'b1);
    expect_word("t5b_hdr", 32'hA506_0000);
    expect_word("t5b_w0", 32'h0000_0061);
`ifdef PACKER_TRAILER_EN
    expect_word("t5b_trl", 32'h5A00_0001);
`endif
    drain("t5b_extra");

    // almost_full on the lane-3 eop byte drops in DATA
    send(8'h71, 1'b1, 1'b0);
    send(8'h72, 1'b0, 1'b0);
    send(8'h73, 1'b0, 1'b0);
    fifo_almost_full = 1'b1;
    send(8'h74, 1'b0, 1'b1);
    fifo_almost_full = 1'b0;
    expect_word("t6_hdr", 32'hA507_0000);
    drain("t6_extra");
    chk("t6_drop", 32'(drop_cnt), 32'd2);
    chk("t6_seq", 32'(pkt_seq), 32'd8);

    // reset mid-packet clears everything
    send(8'h81, 1'b1, 1'b0);
    send(8'h82, 1'b0, 1'b0);
    send(8'h83, 1'b0, 1'b0);
    expect_word("t7_hdr", 32'hA508_0000);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t7_rst_ready", 32'(rx_ready), 32'd0);
    chk("t7_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t7_rst_data", fifo_wr_data, 32'h0);
    chk("t7_rst_drop", 32'(drop_cnt), 32'd0);
    chk("t7_rst_seq", 32'(pkt_seq), 32'd0);
    sys_rst = 1'b0;
    drain("t7_no_partial");
    send(8'h91, 1'b1, 1'b1);
    expect_word("t7b_hdr", 32'hA500_0000);
    expect_word("t7b_w0", 32'h0000_0091);
`ifdef PACKER_TRAILER_EN
    expect_word("t7b_trl", 32'h5A00_0001);
`endif
    drain("t7b_extra");
    chk("t7b_seq", 32'(pkt_seq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
